// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      FAULT = 3'd4
   } state_t;

   localparam int          INSN_BYTES = 4;
   localparam logic [31:0] NOP        = 32'h0000_0013;

endpackage

// File: rtl/ifetch_if.sv
// Bus bundle between the fetch stage, instruction memory, decode and execute.
interface ifetch_if #(
   parameter int WIDTH = 32
);

   // imem: a request transfers on a cycle with imem_req && imem_gnt; its single
   // response arrives later as one imem_rvalid pulse. Decode: a word transfers on
   // a cycle with ins_valid && ins_ready; ins/pc_out hold while ins_valid && !ins_ready.
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_gnt;
   logic             imem_rvalid;
   logic [31:0]      imem_rdata;
   logic             ins_valid;
   logic             ins_ready;
   logic [31:0]      ins;
   logic [WIDTH-1:0] pc_out;
   logic             redirect;
   logic [WIDTH-1:0] redirect_pc;
   logic             misalign;

   modport master (
      output imem_req, imem_addr, ins_valid, ins, pc_out, misalign,
      input  imem_gnt, imem_rvalid, imem_rdata, ins_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, ins_valid, ins, pc_out, misalign,
      output imem_gnt, imem_rvalid, imem_rdata, ins_ready, redirect, redirect_pc
   );

endinterface

// File: rtl/ifetch_pc.sv
// Program counter register: a redirect load takes priority over the post-grant increment.
module ifetch_pc
   import ifetch_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   output logic [WIDTH-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + WIDTH'(INSN_BYTES);
      end
   end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: one outstanding imem read, word handed to decode with its PC.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirect traps into FAULT until reset.
module ifetch
   import ifetch_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic      clk,
   input  logic      rst_n,
   ifetch_if.master  bus,
   output state_t    state_dbg
);

   state_t           state;
   logic             drop;
   logic             req_q;
   logic             valid_q;
   logic             misalign_q;
   logic [31:0]      ins_q;
   logic [WIDTH-1:0] pc_out_q;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] target;
   logic             bad_align;
   logic             take_redirect;
   logic             grant;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign target    = bus.redirect_pc;
   assign bad_align = (bus.redirect_pc[1:0] != 2'b00);
`else
   assign target    = bus.redirect_pc & ~WIDTH'(INSN_BYTES - 1);
   assign bad_align = 1'b0;
`endif

   assign take_redirect = bus.redirect && (state != FAULT);
   assign grant         = (state == REQ) && bus.imem_gnt;

   ifetch_pc #(
      .WIDTH    (WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (take_redirect),
      .load_val (target),
      .inc      (grant),
      .pc       (pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         drop       <= 1'b0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
         ins_q      <= '0;
         pc_out_q   <= RESET_PC;
      end else if (take_redirect && bad_align) begin
         state      <= FAULT;
         misalign_q <= 1'b1;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         drop       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= REQ;
               req_q <= 1'b1;
            end
            REQ: begin
               if (bus.imem_gnt) begin
                  // A redirect in the grant cycle makes this request stale.
                  pc_out_q <= pc;
                  state    <= WAIT;
                  req_q    <= 1'b0;
                  drop     <= take_redirect;
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  if (drop || take_redirect) begin
                     state <= REQ;
                     req_q <= 1'b1;
                     drop  <= 1'b0;
                  end else begin
                     ins_q   <= bus.imem_rdata;
                     valid_q <= 1'b1;
                     state   <= HOLD;
                  end
               end else if (take_redirect) begin
                  drop <= 1'b1;
               end
            end
            HOLD: begin
               if (take_redirect || bus.ins_ready) begin
                  valid_q <= 1'b0;
                  state   <= REQ;
                  req_q   <= 1'b1;
               end
            end
            FAULT: begin
               state <= FAULT;
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = pc;
   assign bus.ins_valid = valid_q;
   assign bus.ins       = ins_q;
   assign bus.pc_out    = pc_out_q;
   assign bus.misalign  = misalign_q;
   assign state_dbg     = state;

endmodule
